// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode encodings and default width for the ALU.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int unsigned C_DEFAULT_WIDTH = 16;

    // 3-bit operation select encodings
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_INC = 3'b111;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Combinational ALU datapath: result plus next overflow,
//                zero and negative flags.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned N = C_DEFAULT_WIDTH
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [2:0]   op_i,
    input  logic         mov_sel_i,
    output logic [N-1:0] result_o,
    output logic         ovf_o,
    output logic         zero_o,
    output logic         neg_o
);

    // Carry-out is simply dropped by keeping every sum N bits wide
    logic [N-1:0] w_add;
    logic [N-1:0] w_sub;
    logic [N-1:0] w_inc;

    assign w_add = a_i + b_i;
    assign w_sub = a_i - b_i;
    assign w_inc = a_i + N'(1);

    // Opcode decode: select result and signed-overflow for the operation
    always_comb begin
        result_o = '0;
        ovf_o    = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = w_add;
                ovf_o    = (a_i[N-1] == b_i[N-1]) && (w_add[N-1] != a_i[N-1]);
            end
            OP_SUB: begin
                result_o = w_sub;
                ovf_o    = (a_i[N-1] != b_i[N-1]) && (w_sub[N-1] != a_i[N-1]);
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_NOT: result_o = ~a_i;
            OP_MOV: result_o = mov_sel_i ? b_i : a_i;
            OP_INC: begin
                // The implicit second operand (+1) is always positive
                result_o = w_inc;
                ovf_o    = !a_i[N-1] && w_inc[N-1];
            end
            default: begin
                result_o = '0;
                ovf_o    = 1'b0;
            end
        endcase
    end

    assign zero_o = (result_o == '0);
    assign neg_o  = result_o[N-1];

endmodule : alu_core
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Registered ALU. Result and flags load together on enabled
//                clock edges; asynchronous active-high reset clears them.
//  Revision    : 1.0  initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int unsigned N = C_DEFAULT_WIDTH
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   op,
    input  logic         clk,
    input  logic         en,
    input  logic         rst,
    input  logic         mov_sel,
    output logic [N-1:0] sum,
    output logic         o_flag,
    output logic         z_flag,
    output logic         n_flag
);

    logic [N-1:0] sum_d;
    logic         o_d;
    logic         z_d;
    logic         n_d;

    logic [N-1:0] sum_q;
    logic         o_q;
    logic         z_q;
    logic         n_q;

    alu_core #(
        .N (N)
    ) u_core (
        .a_i       (A),
        .b_i       (B),
        .op_i      (op),
        .mov_sel_i (mov_sel),
        .result_o  (sum_d),
        .ovf_o     (o_d),
        .zero_o    (z_d),
        .neg_o     (n_d)
    );

    // Result and flags share one enable so they never update partially
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            o_q   <= 1'b0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
        end else if (en) begin
            sum_q <= sum_d;
            o_q   <= o_d;
            z_q   <= z_d;
            n_q   <= n_d;
        end
    end

    assign sum    = sum_q;
    assign o_flag = o_q;
    assign z_flag = z_q;
    assign n_flag = n_q;

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu
//  Description : Self-checking bench for alu: directed corner cases plus
//                randomized operations against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu;

    localparam int unsigned N = 16;

    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   op;
    logic         clk;
    logic         en;
    logic         rst;
    logic         mov_sel;
    logic [N-1:0] sum;
    logic         o_flag;
    logic         z_flag;
    logic         n_flag;

    int checks   = 0;
    int failures = 0;

    // Expected register contents
    logic [N-1:0] exp_sum;
    logic         exp_o;
    logic         exp_z;
    logic         exp_n;

    alu #(.N(N)) dut (
        .A       (A),
        .B       (B),
        .op      (op),
        .clk     (clk),
        .en      (en),
        .rst     (rst),
        .mov_sel (mov_sel),
        .sum     (sum),
        .o_flag  (o_flag),
        .z_flag  (z_flag),
        .n_flag  (n_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed integer arithmetic, overflow = out of 16-bit range.
    // Returns {ovf, zero, neg, result}.
    function automatic logic [N+2:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [2:0] o, input logic ms);
        int          sa;
        int          sb;
        int          s;
        logic [N-1:0] r;
        logic        v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        v  = 1'b0;
        case (o)
            3'd0: begin s = sa + sb; r = s[N-1:0]; v = (s > 32767) || (s < -32768); end
            3'd1: begin s = sa - sb; r = s[N-1:0]; v = (s > 32767) || (s < -32768); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: r = ms ? b : a;
            default: begin s = sa + 1; r = s[N-1:0]; v = (s > 32767); end
        endcase
        return {v, (r == 16'h0000), r[N-1], r};
    endfunction

    task automatic check_outputs(input string tag);
        checks++;
        assert (sum === exp_sum) else begin
            failures++;
            $error("FAIL %s sum observed=%h expected=%h", tag, sum, exp_sum);
        end
        checks++;
        assert (o_flag === exp_o) else begin
            failures++;
            $error("FAIL %s o_flag observed=%b expected=%b", tag, o_flag, exp_o);
        end
        checks++;
        assert (z_flag === exp_z) else begin
            failures++;
            $error("FAIL %s z_flag observed=%b expected=%b", tag, z_flag, exp_z);
        end
        checks++;
        assert (n_flag === exp_n) else begin
            failures++;
            $error("FAIL %s n_flag observed=%b expected=%b", tag, n_flag, exp_n);
        end
    endtask

    // Drive inputs at the falling edge, clock once, update expectations, check
    task automatic step(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] o,
                        input logic ms, input logic e, input string tag);
        logic [N+2:0] m;
        @(negedge clk);
        A = a; B = b; op = o; mov_sel = ms; en = e;
        @(posedge clk);
        #1;
        if (e) begin
            m       = model(a, b, o, ms);
            exp_o   = m[N+2];
            exp_z   = m[N+1];
            exp_n   = m[N];
            exp_sum = m[N-1:0];
        end
        check_outputs(tag);
    endtask

    task automatic set_exp(input logic [N-1:0] s, input logic o, input logic z, input logic n);
        exp_sum = s; exp_o = o; exp_z = z; exp_n = n;
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        A = '0; B = '0; op = 3'd0; mov_sel = 1'b0; en = 1'b0;
        // Reset with stimulus that would otherwise produce nonzero results
        rst = 1'b1;
        A = 16'h1234; en = 1'b1; op = 3'd3;
        #1;
        set_exp(16'h0000, 1'b0, 1'b0, 1'b0);
        check_outputs("reset_async");
        @(posedge clk); #1;
        check_outputs("reset_held");
        @(negedge clk);
        rst = 1'b0;

        // SUB after reset
        step(16'hFF00, 16'h0002, 3'd1, 1'b0, 1'b1, "sub_after_reset");
        checks++;
        assert (sum === 16'hFEFE && n_flag === 1'b1 && z_flag === 1'b0 && o_flag === 1'b0) else begin
            failures++;
            $error("FAIL sub_const observed=%h expected=FEFE", sum);
        end

        // INC then hold
        step(16'h004E, 16'h0000, 3'd7, 1'b0, 1'b1, "inc");
        checks++;
        assert (sum === 16'h004F) else begin
            failures++;
            $error("FAIL inc_const observed=%h expected=004F", sum);
        end
        step(16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, "hold1");
        step(16'hFFFF, 16'h0001, 3'd1, 1'b1, 1'b0, "hold2");

        // XOR then INC
        step(16'hFF00, 16'h0002, 3'd4, 1'b0, 1'b1, "xor");
        step(16'h0007, 16'h0002, 3'd7, 1'b0, 1'b1, "inc7");

        // Overflow corners
        step(16'h7FFF, 16'h0001, 3'd0, 1'b0, 1'b1, "add_ovf");
        checks++;
        assert (sum === 16'h8000 && o_flag === 1'b1 && n_flag === 1'b1) else begin
            failures++;
            $error("FAIL add_ovf_const observed=%h/%b expected=8000/1", sum, o_flag);
        end
        step(16'h8000, 16'h0001, 3'd1, 1'b0, 1'b1, "sub_ovf");
        step(16'h7FFF, 16'h0000, 3'd7, 1'b0, 1'b1, "inc_ovf");
        step(16'h8000, 16'h8000, 3'd0, 1'b0, 1'b1, "add_neg_ovf");
        step(16'h0000, 16'h8000, 3'd1, 1'b0, 1'b1, "sub_minneg");
        step(16'hFFFF, 16'h0000, 3'd7, 1'b0, 1'b1, "inc_wrap");

        // Zero and MOV
        step(16'h1234, 16'h1234, 3'd1, 1'b0, 1'b1, "sub_zero");
        step(16'hAAAA, 16'h5555, 3'd6, 1'b1, 1'b1, "mov_b");
        step(16'hAAAA, 16'h5555, 3'd6, 1'b0, 1'b1, "mov_a");
        step(16'hAAAA, 16'h5555, 3'd5, 1'b0, 1'b1, "not");
        step(16'hF0F0, 16'h3C3C, 3'd2, 1'b0, 1'b1, "and");
        step(16'hF0F0, 16'h3C3C, 3'd3, 1'b0, 1'b1, "or");

        // Randomized operations with occasional disabled cycles
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 16'h7FFF;
            if ($urandom_range(0, 7) == 0) rb = 16'h8000;
            if ($urandom_range(0, 9) == 0) rb = ra;
            step(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), "random");
        end

        // Asynchronous reset between edges while the result is nonzero
        step(16'h1111, 16'h2222, 3'd0, 1'b0, 1'b1, "pre_async");
        @(negedge clk);
        A = 16'h0F0F; op = 3'd3; en = 1'b1;
        rst = 1'b1;
        #1;
        set_exp(16'h0000, 1'b0, 1'b0, 1'b0);
        check_outputs("async_mid");
        @(posedge clk); #1;
        check_outputs("async_held");
        @(negedge clk);
        rst = 1'b0;
        step(16'h0003, 16'h0004, 3'd0, 1'b0, 1'b1, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu
`default_nettype wire
